// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM encoding,
// instruction width, default NOP word and the IF/ID slot bundle.
package instr_fetch_pkg;

  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [31:0]     pc;
    logic            fault;
  } if_id_t;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory bus: request/address out, ready in,
// one response (rvalid/rdata) per accepted request.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic            imem_req;
  logic [31:0]     imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/instr_fetch_if_id_slot.sv
// IF/ID holding register. Ports: clk, rst, load/clear/consume,
// din bundle in; valid and held bundle out. clear beats load.
module if_id_slot
  import instr_fetch_pkg::*;
#(
  parameter logic [ILEN-1:0] NOP_WORD = NOP_DEFAULT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   clear,
  input  logic   consume,
  input  if_id_t din,
  output logic   valid,
  output if_id_t dout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= 1'b0;
      dout.instr <= NOP_WORD;
      dout.pc    <= '0;
      dout.fault <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding request, flush/drop handling,
// misaligned-PC fault. Ports: clk, rst, pc/pc_advance/pc_next,
// flush, imem bus (master), IF/ID slot outputs, id_ready.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [ILEN-1:0] NOP_WORD = NOP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc,
  output logic             pc_advance,
  output logic [31:0]      pc_next,
  input  logic             flush,
  instr_fetch_if.master    mem,
  output logic             if_valid,
  output logic [ILEN-1:0]  if_instr,
  output logic [31:0]      if_pc,
  output logic             if_fault,
  input  logic             id_ready
);

  fetch_state_t state;
  logic [31:0]  req_pc;

  logic   slot_free;
  logic   misal;
  logic   in_req;
  logic   hs;
  logic   resp_ok;
  logic   fault_ld;
  logic   slot_ld;
  if_id_t slot_din;
  if_id_t slot_dout;

  assign slot_free = !if_valid || id_ready;
  assign misal     = misaligned(pc);
  assign in_req    = (state == REQ);

  assign mem.imem_req  = !rst && in_req && slot_free && !misal;
  assign mem.imem_addr = pc;

  assign hs         = mem.imem_req && mem.imem_ready;
  assign pc_advance = hs && !flush;
  assign pc_next    = pc + 32'd4;

  // A response only fills the slot when it belongs to a live request.
  assign resp_ok  = (state == WAIT) && mem.imem_rvalid && !flush;
  assign fault_ld = !rst && in_req && slot_free && misal && !flush;
  assign slot_ld  = resp_ok || fault_ld;

  always_comb begin
    slot_din.instr = mem.imem_rdata;
    slot_din.pc    = req_pc;
    slot_din.fault = 1'b0;
    if (fault_ld) begin
      slot_din.instr = NOP_WORD;
      slot_din.pc    = pc;
      slot_din.fault = 1'b1;
    end
  end

  if_id_slot #(
    .NOP_WORD(NOP_WORD)
  ) u_slot (
    .clk    (clk),
    .rst    (rst),
    .load   (slot_ld),
    .clear  (flush),
    .consume(id_ready),
    .din    (slot_din),
    .valid  (if_valid),
    .dout   (slot_dout)
  );

  assign if_instr = slot_dout.instr;
  assign if_pc    = slot_dout.pc;
  assign if_fault = slot_dout.fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      req_pc <= '0;
    end else begin
      unique case (state)
        IDLE: state <= REQ;
        REQ: begin
          // A request accepted under flush is still owed a response.
          if (hs) begin
            req_pc <= pc;
            state  <= flush ? DROP : WAIT;
          end
        end
        WAIT: begin
          if (mem.imem_rvalid) state <= REQ;
          else if (flush)      state <= DROP;
        end
        DROP: begin
          if (mem.imem_rvalid) state <= REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: environment PC
// register, latency-randomized memory, queue-based expectations.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_advance;
  logic [31:0] pc_next;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;
  logic        id_ready;

  instr_fetch_if bus();

  instr_fetch #(
    .NOP_WORD(NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .pc_advance(pc_advance),
    .pc_next   (pc_next),
    .flush     (flush),
    .mem       (bus),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .if_fault  (if_fault),
    .id_ready  (id_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int n_chk = 0;
  int n_fail = 0;

  bit          pend = 0;
  bit          pkill = 0;
  logic [31:0] paddr = '0;
  int          cnt = 0;
  bit          adv_s = 0;
  bit          prev_rst = 0;
  bit          idle_cyc = 0;
  bit          rst_req = 1;
  bit          hit = 0;
  logic [31:0] tgt = '0;
  logic [31:0] start_pc = '0;
  int p_flush, p_stall, p_nready, p_mis, lat_max;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Expected behaviour derived from the fetch rules, evaluated once
  // per cycle with all inputs settled.
  task automatic model();
    bit had_pend;
    bit exp_req;
    bit acc;
    idle_cyc = prev_rst && !rst;
    had_pend = pend;
    check("pc_next", pc_next, pc + 32'd4);
    if (rst) begin
      check("rst_imem_req", 32'(bus.imem_req), 32'd0);
      check("rst_pc_advance", 32'(pc_advance), 32'd0);
      if (prev_rst) begin
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_instr", if_instr, NOP);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_fault", 32'(if_fault), 32'd0);
      end
      pend = 0;
      q.delete();
      adv_s = 0;
      prev_rst = 1;
      return;
    end
    exp_req = !idle_cyc && !had_pend && pc[1:0] == 2'b00 &&
              (!if_valid || id_ready);
    check("imem_req", 32'(bus.imem_req), 32'(exp_req));
    acc = exp_req && bus.imem_ready;
    check("pc_advance", 32'(pc_advance), 32'(acc && !flush));
    if (had_pend && flush) pkill = 1;
    if (had_pend && bus.imem_rvalid) begin
      if (!pkill) q.push_back('{mem_word(paddr), paddr, 1'b0});
      pend = 0;
    end
    if (bus.imem_req && bus.imem_ready) begin
      check("imem_addr", bus.imem_addr, pc);
      pend  = 1;
      paddr = pc;
      pkill = flush;
      cnt   = int'($urandom_range(lat_max, 1)) - 1;
    end
    if (!idle_cyc && !had_pend && pc[1:0] != 2'b00 &&
        (!if_valid || id_ready) && !flush)
      q.push_back('{NOP, pc, 1'b1});
    adv_s = pc_advance;
    prev_rst = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rst_req)    pc = start_pc;
      else if (flush) pc = tgt;
      else if (adv_s) pc = pc + 32'd4;
      rst = rst_req;
      if (rst_req) pend = 0;
      if (pend && cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = pkill ? 32'hDEAD_BEEF : mem_word(paddr);
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        if (pend) cnt--;
      end
      flush = !rst_req && ($urandom_range(99) < 32'(p_flush));
      tgt = $urandom & 32'h0000_0FFC;
      if ($urandom_range(99) < 32'(p_mis))
        tgt[1:0] = 2'($urandom_range(3, 1));
      id_ready = $urandom_range(99) >= 32'(p_stall);
      bus.imem_ready = $urandom_range(99) >= 32'(p_nready);
      @(negedge clk);
      model();
    end
  endtask

  // Monitor: each slot entry leaving decode is compared in order.
  always @(negedge clk) begin
    if (!rst && if_valid && (id_ready || flush)) begin
      if (q.size() == 0) begin
        check("spurious_if_valid", 32'(if_valid), 32'd0);
      end else begin
        e = q.pop_front();
        if (id_ready) begin
          check("if_instr", if_instr, e.instr);
          check("if_pc", if_pc, e.pc);
          check("if_fault", 32'(if_fault), 32'(e.fault));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    id_ready = 1'b1;
    pc = '0;
    bus.imem_ready = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    p_flush = 0;
    p_stall = 0;
    p_nready = 0;
    p_mis = 0;
    lat_max = 1;

    rst_req = 1;
    run(3);
    rst_req = 0;
    run(20);

    p_stall = 40;
    p_nready = 30;
    lat_max = 3;
    run(200);

    p_flush = 10;
    run(400);

    p_mis = 20;
    run(400);

    p_mis = 0;
    p_flush = 20;
    hit = 0;
    for (int k = 0; k < 50 && !hit; k++) begin
      run(1);
      hit = pend;
    end
    check("wait_bound", 32'(hit), 32'd1);

    p_flush = 0;
    p_stall = 0;
    p_nready = 0;
    lat_max = 1;
    start_pc = 32'hFFFF_FFF0;
    rst_req = 1;
    run(2);
    rst_req = 0;
    run(20);

    run(10);
    check("drain", 32'(q.size() <= 1), 32'd1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter NOP_WORD, default 32'h0000_0000, instruction word presented with a fault or after reset.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pc  input  32  current program counter from the PC register.
REQ-005 pc_advance  output  1  one-cycle pulse; PC shall load pc_next (PCWrite-style).
REQ-006 pc_next  output  32  pc + 4, mod 2^32.
REQ-007 flush  input  1  redirect (taken branch/jump) this cycle; kill in-flight and held fetch.
REQ-008 imem_req  output  1  fetch request valid.
REQ-009 imem_addr  output  32  fetch byte address.
REQ-010 imem_ready  input  1  memory accepts request when imem_req && imem_ready.
REQ-011 imem_rvalid  input  1  response valid, exactly one per accepted request, latency >= 1 cycle.
REQ-012 imem_rdata  input  32  response instruction word.
REQ-013 if_valid / if_instr / if_pc / if_fault  output  1/32/32/1  IF/ID slot: valid, instruction, its PC, misalignment flag.
REQ-014 id_ready  input  1  decode consumes slot when if_valid && id_ready.

Function
REQ-015 FSM states: IDLE, REQ, WAIT, DROP; at most one outstanding request.
REQ-016 IDLE -> REQ unconditionally on the first cycle after reset is released.
REQ-017 In REQ, imem_req = 1 only when slot free: !if_valid || id_ready; imem_addr = pc.
REQ-018 Handshake in REQ without flush: latch req_pc = pc, pulse pc_advance, go WAIT.
REQ-019 In WAIT, on imem_rvalid without flush: if_valid=1, if_instr=imem_rdata, if_pc=req_pc, if_fault=0 next cycle; go REQ.
REQ-020 Slot shall never be overwritten while if_valid && !id_ready; REQ-017 guarantees a free slot at response.
REQ-021 Consume without refill clears if_valid next cycle; consume and refill in same cycle loads the new word.
REQ-022 Misaligned pc (pc[1:0] != 0) in REQ with slot free: no imem_req; load slot with NOP_WORD, if_pc=pc, if_fault=1; no pc_advance; stay REQ until flush.
REQ-023 flush in any state: if_valid cleared next cycle, pc_advance suppressed that cycle.
REQ-024 flush in REQ with same-cycle handshake: request counts as outstanding; go DROP.
REQ-025 flush in WAIT without rvalid: go DROP; flush in WAIT with rvalid: discard data, go REQ.
REQ-026 DROP: imem_req=0; on imem_rvalid discard data, go REQ; further flush in DROP stays DROP.
REQ-027 imem_rvalid outside WAIT/DROP shall be ignored (protocol error, no state change).
REQ-028 pc_next = pc + 4 combinational, wraps 32'hFFFF_FFFC -> 32'h0000_0000.

Reset
REQ-029 While rst=1: state=IDLE, if_valid=0, if_instr=NOP_WORD, if_pc=0, if_fault=0, imem_req=0, pc_advance=0, req_pc=0.
REQ-030 rst mid-WAIT abandons the outstanding response; memory is reset on the same rst.

Structure
REQ-031 Shared package holds FSM state encoding (2-bit), NOP_WORD default, instruction width 32.
REQ-032 One sub-module natural: if_id_slot (valid/instr/pc/fault holding register with load/clear/consume).

Verification
REQ-033 Zero-wait memory, pc=0x0000_0000 then 0x0000_0004, id_ready=1 -> words at 0x0 and 0x4 appear in order, one pc_advance per handshake.
REQ-034 id_ready=0 for 5 cycles with slot full -> imem_req=0 throughout, if_instr stable; id_ready=1 -> next fetch issued same cycle.
REQ-035 flush in WAIT, response arrives 3 cycles later with 0xDEAD_BEEF -> word never appears on if_instr; next request uses redirected pc.
REQ-036 flush same cycle as imem_rvalid -> data discarded, state REQ next cycle, if_valid=0.
REQ-037 pc=0x0000_0006 -> if_valid=1, if_fault=1, if_instr=NOP_WORD, no imem_req, no pc_advance.
REQ-038 rst asserted in WAIT -> all outputs at reset values next cycle; pc=0xFFFF_FFFC gives pc_next=0x0000_0000.
